// File: rtl/dma_guard_pkg.sv
// Shared definitions for the multi-region DMA/exec guard:
// FSM state encodings plus the bit positions used in the mode and cause vectors.
package dma_guard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  localparam int MODE_EXEC  = 0;
  localparam int MODE_ADDR  = 1;

  localparam int CAUSE_EXEC = 0;
  localparam int CAUSE_ADDR = 1;

endpackage

// File: rtl/dma_region_check.sv
// Per-region hit detection: inclusive word-range compare of pc and dma_addr,
// gated by the region's EXEC/ADDR mode bits and the DMA valid strobe.
module dma_region_check
  import dma_guard_pkg::*;
#(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] SIZE   = ADDR_W'(2),
  parameter logic [1:0]        MODE   = 2'b01
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_en,
  output logic              hit_exec,
  output logic              hit_addr
);

  // One extra bit so a region ending exactly at the top of the address space is legal.
  localparam logic [ADDR_W:0] END_SUM   = {1'b0, BASE} + {1'b0, SIZE};
  localparam logic [ADDR_W:0] LIMIT     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_WIDE = END_SUM - (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] LAST    = LAST_WIDE[ADDR_W-1:0];

  generate
    if (END_SUM > LIMIT) begin : g_bad_end
      $error("dma_region_check: BASE+SIZE exceeds the address space");
    end
    if ((SIZE == '0) || SIZE[0]) begin : g_bad_size
      $error("dma_region_check: SIZE must be even and nonzero");
    end
  endgenerate

  logic in_exec;
  logic in_addr;

  always_comb begin
    in_exec  = (pc >= BASE) && (pc <= LAST);
    in_addr  = (dma_addr >= BASE) && (dma_addr <= LAST);
    hit_exec = MODE[MODE_EXEC] & dma_en & in_exec;
    hit_addr = MODE[MODE_ADDR] & dma_en & in_addr;
  end

endmodule

// File: rtl/dma_guard_multi.sv
// Multi-region DMA/exec guard: holds the system in reset after any violation,
// records the first violating regions/cause and counts RUN->KILL events.
module dma_guard_multi
  import dma_guard_pkg::*;
#(
  parameter int                              NUM_REGIONS   = 2,
  parameter int                              ADDR_W        = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE   = {16'hA000, 16'hE000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_SIZE   = {16'h0200, 16'h1000},
  parameter logic [NUM_REGIONS*2-1:0]        REGION_MODE   = {2'b10, 2'b01},
  parameter logic [ADDR_W-1:0]               RESET_HANDLER = '0,
  parameter int                              HOLD_CYCLES   = 4,
  parameter int                              CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      pc,
  input  logic [ADDR_W-1:0]      dma_addr,
  input  logic                   dma_en,
  input  logic                   viol_clr,
  output logic                   reset,
  output logic [NUM_REGIONS-1:0] viol_region,
  output logic [1:0]             viol_cause,
  output logic [CNT_W-1:0]       viol_count
);

  localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  generate
    if ((NUM_REGIONS < 1) || (NUM_REGIONS > 8)) begin : g_bad_regions
      $error("dma_guard_multi: NUM_REGIONS must be 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("dma_guard_multi: HOLD_CYCLES must be at least 1");
    end
  endgenerate

  logic [NUM_REGIONS-1:0] hit_exec;
  logic [NUM_REGIONS-1:0] hit_addr;
  logic [NUM_REGIONS-1:0] viol_vec;
  logic                   invalid;
  logic [1:0]             cause_now;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    dma_region_check #(
      .ADDR_W (ADDR_W),
      .BASE   (REGION_BASE[i*ADDR_W +: ADDR_W]),
      .SIZE   (REGION_SIZE[i*ADDR_W +: ADDR_W]),
      .MODE   (REGION_MODE[i*2 +: 2])
    ) u_check (
      .pc       (pc),
      .dma_addr (dma_addr),
      .dma_en   (dma_en),
      .hit_exec (hit_exec[i]),
      .hit_addr (hit_addr[i])
    );
  end

  always_comb begin
    cause_now             = '0;
    viol_vec              = hit_exec | hit_addr;
    invalid               = |viol_vec;
    cause_now[CAUSE_EXEC] = |hit_exec;
    cause_now[CAUSE_ADDR] = |hit_addr;
  end

  state_t                 state, state_next;
  logic [HOLD_W-1:0]      hold, hold_next;
  logic [NUM_REGIONS-1:0] region_next;
  logic [1:0]             cause_next;
  logic [CNT_W-1:0]       count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= KILL;
      hold        <= HOLD_INIT;
      viol_region <= '0;
      viol_cause  <= '0;
      viol_count  <= '0;
    end else begin
      state       <= state_next;
      hold        <= hold_next;
      viol_region <= region_next;
      viol_cause  <= cause_next;
      viol_count  <= count_next;
    end
  end

  // A violation always wins over viol_clr; a nonzero capture is never overwritten.
  always_comb begin
    state_next  = state;
    hold_next   = hold;
    region_next = viol_region;
    cause_next  = viol_cause;
    count_next  = viol_count;
    case (state)
      RUN: begin
        if (invalid) begin
          state_next = KILL;
          hold_next  = HOLD_INIT;
          if (viol_count != CNT_MAX) begin
            count_next = viol_count + CNT_W'(1);
          end
          if (viol_region == '0) begin
            region_next = viol_vec;
            cause_next  = cause_now;
          end
        end else if (viol_clr) begin
          region_next = '0;
          cause_next  = '0;
        end
      end
      KILL: begin
        if (invalid) begin
          hold_next = HOLD_INIT;
        end else if (hold != '0) begin
          hold_next = hold - HOLD_W'(1);
        end else if (pc == RESET_HANDLER) begin
          state_next = RUN;
        end
      end
    endcase
  end

  assign reset = (state == KILL);

endmodule

// File: tb/tb_dma_guard_multi.sv
// Scoreboard bench for dma_guard_multi: directed steps push hand-computed
// expectations; a monitor compares them against the DUT on the falling edge.
module tb_dma_guard_multi;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        viol_clr;
  logic        reset;
  logic [1:0]  viol_region;
  logic [1:0]  viol_cause;
  logic [7:0]  viol_count;

  typedef struct {
    int         cyc;
    string      name;
    logic       rst;
    logic [1:0] region;
    logic [1:0] cause;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  event check_now;

  dma_guard_multi dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .dma_addr    (dma_addr),
    .dma_en      (dma_en),
    .viol_clr    (viol_clr),
    .reset       (reset),
    .viol_region (viol_region),
    .viol_cause  (viol_cause),
    .viol_count  (viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (e.cyc != cycle || reset !== e.rst || viol_region !== e.region ||
        viol_cause !== e.cause || viol_count !== e.count) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d (due %0d): got reset=%b region=%b cause=%b count=%h, expected reset=%b region=%b cause=%b count=%h",
               e.name, cycle, e.cyc, reset, viol_region, viol_cause, viol_count,
               e.rst, e.region, e.cause, e.count);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or check_now);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // One clock step: drive at the falling edge, expect the result after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [15:0] p, input logic [15:0] a,
                               input logic en, input logic clr, input string name,
                               input logic er, input logic [1:0] ereg,
                               input logic [1:0] ecause, input logic [7:0] ecnt);
    @(negedge clk);
    rst_n    = r;
    pc       = p;
    dma_addr = a;
    dma_en   = en;
    viol_clr = clr;
    sb.push_back('{cyc: cycle + 1, name: name, rst: er, region: ereg, cause: ecause, count: ecnt});
  endtask

  task automatic runStep(input logic [15:0] p, input logic [15:0] a, input logic en,
                         input logic clr, input string name, input logic er,
                         input logic [1:0] ereg, input logic [1:0] ecause,
                         input logic [7:0] ecnt);
    applyStimulus(1'b1, p, a, en, clr, name, er, ereg, ecause, ecnt);
  endtask

  // From a fresh KILL entry: three more hold cycles, then release with pc at the handler.
  task automatic recoverSeq(input logic [1:0] ereg, input logic [1:0] ecause,
                            input logic [7:0] ecnt);
    for (int i = 0; i < 3; i++) runStep(16'h0000, 16'h0000, 1'b0, 1'b0, "hold", 1'b1, ereg, ecause, ecnt);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b0, "release", 1'b0, ereg, ecause, ecnt);
  endtask

  task automatic powerUp;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "reset_state", 1'b1, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "powerup_hold", 1'b1, 2'b00, 2'b00, 8'h00);
    applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "powerup_release", 1'b0, 2'b00, 2'b00, 8'h00);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; pc = '0; dma_addr = '0; dma_en = 1'b0; viol_clr = 1'b0;
    repeat (2) @(negedge clk);
    powerUp();
    runStep(16'h0000, 16'h0000, 1'b0, 1'b0, "run_idle", 1'b0, 2'b00, 2'b00, 8'h00);

    // Exec violations at both inclusive bounds of region 0
    runStep(16'hE000, 16'h0100, 1'b1, 1'b0, "exec_first", 1'b1, 2'b01, 2'b01, 8'h01);
    recoverSeq(2'b01, 2'b01, 8'h01);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "clr", 1'b0, 2'b00, 2'b00, 8'h01);
    runStep(16'hEFFE, 16'h0100, 1'b1, 1'b0, "exec_last", 1'b1, 2'b01, 2'b01, 8'h02);
    recoverSeq(2'b01, 2'b01, 8'h02);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "clr", 1'b0, 2'b00, 2'b00, 8'h02);
    runStep(16'hF000, 16'h0100, 1'b1, 1'b0, "exec_last_p2", 1'b0, 2'b00, 2'b00, 8'h02);
    runStep(16'hDFFE, 16'h0100, 1'b1, 1'b0, "exec_first_m2", 1'b0, 2'b00, 2'b00, 8'h02);
    runStep(16'hE000, 16'h0100, 1'b0, 1'b0, "exec_no_dma", 1'b0, 2'b00, 2'b00, 8'h02);

    // Address violations on region 1
    runStep(16'h4000, 16'hA1FE, 1'b1, 1'b0, "addr_last", 1'b1, 2'b10, 2'b10, 8'h03);
    recoverSeq(2'b10, 2'b10, 8'h03);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "clr", 1'b0, 2'b00, 2'b00, 8'h03);
    runStep(16'h4000, 16'hA200, 1'b1, 1'b0, "addr_last_p2", 1'b0, 2'b00, 2'b00, 8'h03);
    runStep(16'h4000, 16'h9FFE, 1'b1, 1'b0, "addr_first_m2", 1'b0, 2'b00, 2'b00, 8'h03);
    runStep(16'hA000, 16'h0100, 1'b1, 1'b0, "mode_r1_no_exec", 1'b0, 2'b00, 2'b00, 8'h03);
    runStep(16'h0100, 16'hE000, 1'b1, 1'b0, "mode_r0_no_addr", 1'b0, 2'b00, 2'b00, 8'h03);
    runStep(16'h4000, 16'hA000, 1'b1, 1'b1, "addr_first_clr", 1'b1, 2'b10, 2'b10, 8'h04);
    recoverSeq(2'b10, 2'b10, 8'h04);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "clr", 1'b0, 2'b00, 2'b00, 8'h04);

    // Simultaneous hit, then a sticky capture across a later violation
    runStep(16'hE010, 16'hA000, 1'b1, 1'b0, "both_hit", 1'b1, 2'b11, 2'b11, 8'h05);
    recoverSeq(2'b11, 2'b11, 8'h05);
    runStep(16'hE000, 16'h0100, 1'b1, 1'b0, "sticky", 1'b1, 2'b11, 2'b11, 8'h06);
    recoverSeq(2'b11, 2'b11, 8'h06);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "clr", 1'b0, 2'b00, 2'b00, 8'h06);

    // Hold restart by a hit inside KILL; clr and wrong pc do not release
    runStep(16'hE000, 16'h0000, 1'b1, 1'b0, "hold_enter", 1'b1, 2'b01, 2'b01, 8'h07);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "kill_clr_ignored", 1'b1, 2'b01, 2'b01, 8'h07);
    runStep(16'h0000, 16'hA000, 1'b1, 1'b0, "kill_rehit", 1'b1, 2'b01, 2'b01, 8'h07);
    for (int i = 0; i < 3; i++) runStep(16'h0000, 16'h0000, 1'b0, 1'b0, "rehold", 1'b1, 2'b01, 2'b01, 8'h07);
    runStep(16'h1234, 16'h0000, 1'b0, 1'b0, "kill_wrong_pc", 1'b1, 2'b01, 2'b01, 8'h07);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b0, "rehold_release", 1'b0, 2'b01, 2'b01, 8'h07);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b1, "clr", 1'b0, 2'b00, 2'b00, 8'h07);

    // Counter saturation
    c = 7;
    for (int k = 0; k < 300; k++) begin
      c = (c < 255) ? c + 1 : 255;
      runStep(16'hE000, 16'h0000, 1'b1, 1'b0, "sat_viol", 1'b1, 2'b01, 2'b01, 8'(c));
      recoverSeq(2'b01, 2'b01, 8'(c));
    end

    // Asynchronous reset in the middle of a KILL hold
    runStep(16'hE000, 16'h0000, 1'b1, 1'b0, "sat_final", 1'b1, 2'b01, 2'b01, 8'hFF);
    runStep(16'h0000, 16'h0000, 1'b0, 1'b0, "kill_before_async", 1'b1, 2'b01, 2'b01, 8'hFF);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 sb.push_back('{cyc: cycle, name: "async_reset", rst: 1'b1, region: 2'b00, cause: 2'b00, count: 8'h00});
    -> check_now;
    powerUp();

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_guard_multi.md
Name: dma_guard_multi

Overview:
- Parametrised successor of the single-region DMA/exec guard: it watches N protected regions instead of one.
- Per-region mode selects exec-based blocking (any DMA while pc is inside the region) and/or address-based blocking (DMA targeting the region).
- A violation drives the system reset. The block leaves KILL only after a minimum hold time and after pc reaches the reset handler with no violation present.
- Latches the violating region and cause, and keeps a saturating violation counter for attestation and debug readout.

Parameters:
- NUM_REGIONS, 2, number of protected regions (1..8).
- ADDR_W, 16, width of pc and dma_addr.
- REGION_BASE, {16'hA000,16'hE000}, packed NUM_REGIONS*ADDR_W; region i is slice i (region 0 = E000).
- REGION_SIZE, {16'h0200,16'h1000}, packed NUM_REGIONS*ADDR_W; byte size of region i, even and nonzero.
- REGION_MODE, {2'b10,2'b01}, packed NUM_REGIONS*2; bit0 = EXEC mode, bit1 = ADDR mode.
- RESET_HANDLER, 16'h0000, pc value that allows leaving KILL.
- HOLD_CYCLES, 4, minimum cycles reset stays asserted after entering KILL (>=1).
- CNT_W, 8, width of the violation counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current program counter.
- dma_addr  in  ADDR_W  DMA bus address.
- dma_en  in  1  DMA access valid this cycle.
- viol_clr  in  1  clears viol_region/viol_cause; ignored while in KILL.
- reset  out  1  registered system-reset request, active high.
- viol_region  out  NUM_REGIONS  one-hot (or multi-hot) latched regions of the first violation.
- viol_cause  out  2  latched cause of the first violation: bit0 = EXEC, bit1 = ADDR.
- viol_count  out  CNT_W  saturating count of RUN->KILL transitions.

Behaviour:
- Reset is asynchronous, active-low.
  - rst_n=0 → state=KILL, reset=1, hold counter=HOLD_CYCLES-1, viol_region=0, viol_cause=0, viol_count=0.
- Region i bounds: first=BASE_i, last=BASE_i+SIZE_i-2 (last word). The sum is computed at ADDR_W+1 bits; elaboration error if it exceeds 2^ADDR_W.
- in_exec_i = (first_i <= pc <= last_i).
- in_addr_i = (first_i <= dma_addr <= last_i).
- Both bounds are inclusive and must be checked at exactly first, last, first-2 and last+2.
- hit_exec_i = MODE_i[0] & dma_en & in_exec_i.
- hit_addr_i = MODE_i[1] & dma_en & in_addr_i.
- viol_i = hit_exec_i | hit_addr_i; invalid = OR over i. All of this is combinational from the same-cycle inputs.
- State machine, two states, registered on posedge clk:
  - RUN & invalid → KILL. reset=1 on the next edge (1-cycle latency). Load hold counter=HOLD_CYCLES-1. viol_count += 1, saturating at all-ones.
  - RUN & !invalid → RUN, reset=0.
  - KILL & hold counter!=0 → decrement, stay KILL, reset=1.
  - KILL & hold==0 & pc==RESET_HANDLER & !invalid → RUN, reset=0 on the next edge.
  - KILL otherwise → stay KILL, reset=1.
  - A violation while in KILL reloads the hold counter (restarts the hold) but does not increment viol_count.
- Violation capture:
  - On the RUN→KILL edge, if viol_region==0, latch viol_region = {viol_i} and viol_cause = {OR hit_addr, OR hit_exec}. If several regions hit in the same cycle, all are recorded.
  - Later violations never overwrite a nonzero capture (sticky first-cause).
  - viol_clr=1 in RUN clears both fields on the next edge.
  - If viol_clr and a violation occur in the same cycle, the violation capture wins.
- Overlapping regions are legal; each region's hit is evaluated independently.
- Power-up leaves the block in KILL. The system therefore releases only after HOLD_CYCLES cycles and pc==RESET_HANDLER.

Decomposition:
- Shared package dma_guard_pkg holds:
  - state encodings RUN=1'b0, KILL=1'b1;
  - mode bit indices MODE_EXEC=0, MODE_ADDR=1;
  - cause bit indices CAUSE_EXEC=0, CAUSE_ADDR=1.
- Sub-module dma_region_check, instantiated NUM_REGIONS times via generate. Parameters BASE, SIZE, MODE, ADDR_W; inputs pc, dma_addr, dma_en; outputs hit_exec, hit_addr.
- The top level holds the FSM, hold counter, capture registers and saturating counter.

Test Plan:
- Power-up: rst_n low then high, pc=0000, no DMA → reset=1 for 4 cycles, then 0 on the following edge; viol_count=0.
- Exec violation, region 0: in RUN, pc=E000, dma_en=1, dma_addr=0100 → next edge reset=1, viol_region=01, viol_cause=01, viol_count=1. Repeat with pc=EFFE → same; pc=F000 or pc=DFFE → no violation.
- Addr violation, region 1: pc=4000, dma_en=1, dma_addr=A1FE → reset=1, viol_region=10, viol_cause=10. dma_addr=A200 → no violation.
- Simultaneous hit: pc=E010 with dma_addr=A000 → viol_region=11, viol_cause=11. A later violation after recovery does not change the capture until viol_clr is pulsed in RUN.
- Hold and recovery: enter KILL, then pc=0000 at cycle 1 after KILL → stays KILL until the hold expires. Inject a DMA hit at cycle 2 → hold restarts and viol_count is unchanged. Release comes 4 cycles after the last hit, with pc=0000.
- Saturation and async reset: force 300 violation/recover cycles with CNT_W=8 → viol_count=FF. Drop rst_n mid-KILL hold → reset=1 immediately and the counter reads 0.
